// File: rtl/sha256_pkg.sv
// Shared constants, FSM state encoding and the length-byte helper for the SHA-256 padder.
package sha256_pkg;

    localparam int         BLOCK_BITS  = 512;
    localparam int         BLOCK_BYTES = BLOCK_BITS / 8;
    localparam int         LEN_POS     = 56;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    typedef enum logic [1:0] {
        ST_LOAD      = 2'd0,
        ST_EMIT      = 2'd1,
        ST_PAD2      = 2'd2,
        ST_EMIT_LAST = 2'd3
    } padder_state_e;

    // Byte `pos` (LEN_POS..63) of the block carries the 64-bit length, most significant first.
    function automatic logic [7:0] len_byte(input logic [63:0] bit_len, input int pos);
        return bit_len[(BLOCK_BYTES - 1 - pos) * 8 +: 8];
    endfunction

endpackage

// File: rtl/sha256_block_buffer.sv
// 64-byte block store: single byte writes, a 0x80/zero/length pad fill, and an all-zero length fill.
module sha256_block_buffer
    import sha256_pkg::*;
(
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  wr_en_i,
    input  logic [5:0]            idx_i,
    input  logic [7:0]            wr_data_i,
    input  logic                  pad_en_i,
    input  logic                  len_en_i,
    input  logic                  fill_en_i,
    input  logic [63:0]           bit_len_i,
    output logic [BLOCK_BITS-1:0] data_o
);

    logic [7:0] mem_q [BLOCK_BYTES];
    logic [7:0] mem_d [BLOCK_BYTES];

    always_comb begin
        mem_d = mem_q;
        if (fill_en_i) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                mem_d[i] = (i >= LEN_POS) ? len_byte(bit_len_i, i) : 8'h00;
            end
        end else if (pad_en_i) begin
            // Bytes below idx keep the message; the length overlays the tail only when it fits.
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                if (i == int'(idx_i)) begin
                    mem_d[i] = PAD_BYTE;
                end else if (i > int'(idx_i)) begin
                    mem_d[i] = 8'h00;
                end
                if (len_en_i && i >= LEN_POS) begin
                    mem_d[i] = len_byte(bit_len_i, i);
                end
            end
        end else if (wr_en_i) begin
            mem_d[idx_i] = wr_data_i;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        data_o = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            data_o[BLOCK_BITS - 1 - 8 * i -: 8] = mem_q[i];
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: collects bytes into 512-bit blocks and appends 0x80, zeros and the bit length.
// Handshake: a block transfers on a rising edge where block_valid && block_ready; in_ready is high only in LOAD.
module sha256_padder
    import sha256_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_enable,
    input  logic                  input_complete,
    input  logic [7:0]            input_data,
    output logic                  in_ready,
    output logic                  block_valid,
    input  logic                  block_ready,
    output logic [BLOCK_BITS-1:0] block_data,
    output logic                  block_last
);

    localparam logic [5:0] LAST_IDX    = 6'd63;
    localparam logic [5:0] LEN_FIT_IDX = 6'(LEN_POS - 1);

    padder_state_e state_q, state_d;
    logic [5:0]    idx_q, idx_d;
    logic [60:0]   cnt_q, cnt_d;
    logic          pend_q, pend_d;

    logic          wr_en;
    logic          pad_en;
    logic          len_en;
    logic          fill_en;
    logic [63:0]   bit_len;

    assign bit_len = {cnt_q, 3'b000};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        wr_en   = 1'b0;
        pad_en  = 1'b0;
        len_en  = 1'b0;
        fill_en = 1'b0;
        case (state_q)
            ST_LOAD: begin
                // input_complete wins; a byte offered in the same cycle is dropped.
                if (input_complete) begin
                    pad_en = 1'b1;
                    if (idx_q <= LEN_FIT_IDX) begin
                        len_en  = 1'b1;
                        state_d = ST_EMIT_LAST;
                    end else begin
                        pend_d  = 1'b1;
                        state_d = ST_EMIT;
                    end
                end else if (load_enable) begin
                    wr_en = 1'b1;
                    idx_d = idx_q + 6'd1;
                    cnt_d = cnt_q + 61'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (block_ready) begin
                    idx_d = 6'd0;
                    if (pend_q) begin
                        pend_d  = 1'b0;
                        state_d = ST_PAD2;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_PAD2: begin
                fill_en = 1'b1;
                state_d = ST_EMIT_LAST;
            end
            ST_EMIT_LAST: begin
                if (block_ready) begin
                    idx_d   = 6'd0;
                    cnt_d   = 61'd0;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD;
            idx_q   <= 6'd0;
            cnt_q   <= 61'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    sha256_block_buffer u_buffer (
        .clock_i   (clock),
        .reset_i   (reset),
        .wr_en_i   (wr_en),
        .idx_i     (idx_q),
        .wr_data_i (input_data),
        .pad_en_i  (pad_en),
        .len_en_i  (len_en),
        .fill_en_i (fill_en),
        .bit_len_i (bit_len),
        .data_o    (block_data)
    );

    assign in_ready    = (state_q == ST_LOAD);
    assign block_valid = (state_q == ST_EMIT) || (state_q == ST_EMIT_LAST);
    assign block_last  = (state_q == ST_EMIT_LAST);

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: directed messages, expected blocks queued as {last, data}, checked by a monitor.
module tb_sha256_padder;

    logic         clock;
    logic         reset;
    logic         load_enable;
    logic         input_complete;
    logic [7:0]   input_data;
    logic         in_ready;
    logic         block_valid;
    logic         block_ready;
    logic [511:0] block_data;
    logic         block_last;

    logic [512:0] exp_q[$];
    int           n_cmp;
    int           n_fail;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};

    sha256_padder dut (
        .clock          (clock),
        .reset          (reset),
        .load_enable    (load_enable),
        .input_complete (input_complete),
        .input_data     (input_data),
        .in_ready       (in_ready),
        .block_valid    (block_valid),
        .block_ready    (block_ready),
        .block_data     (block_data),
        .block_last     (block_last)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic last, input logic [511:0] data);
        exp_q.push_back({last, data});
    endtask

    // Driver tasks: all entered and left at posedge+#1.
    task automatic wait_in_ready(input string name);
        int budget = 0;
        while (!in_ready && budget < 1000) begin
            @(posedge clock); #1;
            budget++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: in_ready timeout got 0 expected 1", name);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_in_ready("send_byte");
        load_enable = 1'b1;
        input_data  = b;
        @(posedge clock); #1;
        load_enable = 1'b0;
    endtask

    task automatic send_complete(input logic with_byte, input logic [7:0] b);
        wait_in_ready("send_complete");
        input_complete = 1'b1;
        load_enable    = with_byte;
        input_data     = b;
        @(posedge clock); #1;
        input_complete = 1'b0;
        load_enable    = 1'b0;
    endtask

    task automatic send_abc();
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
        send_complete(1'b0, 8'h00);
    endtask

    task automatic wait_drain(input string name);
        int budget = 0;
        while (exp_q.size() != 0 && budget < 2000) begin
            @(posedge clock); #1;
            budget++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d blocks outstanding expected 0", name, exp_q.size());
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (!reset) begin
            if (block_valid && block_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_block: got %h last %0d expected none", block_data, block_last);
                end else begin
                    logic [512:0] e;
                    e = exp_q.pop_front();
                    check("block_data", block_data, e[511:0]);
                    check("block_last", {511'h0, block_last}, {511'h0, e[512]});
                end
            end else if (!block_valid) begin
                check("idle_block_last", {511'h0, block_last}, 512'h0);
            end
        end
    end

    initial begin
        n_cmp          = 0;
        n_fail         = 0;
        reset          = 1'b1;
        load_enable    = 1'b0;
        input_complete = 1'b0;
        input_data     = 8'h00;
        block_ready    = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", {511'h0, in_ready}, 512'h1);
        check("rst_block_valid", {511'h0, block_valid}, 512'h0);
        check("rst_block_last", {511'h0, block_last}, 512'h0);
        check("rst_block_data", block_data, 512'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        // "abc"
        push_exp(1'b1, ABC_BLK);
        send_abc();

        // "abc" with a byte offered alongside input_complete: that byte is dropped
        push_exp(1'b1, ABC_BLK);
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
        send_complete(1'b1, 8'h64);

        // "Go Irish!"
        push_exp(1'b1, {72'h476f20497269736821, 8'h80, 368'h0, 64'h48});
        send_byte(8'h47); send_byte(8'h6f); send_byte(8'h20);
        send_byte(8'h49); send_byte(8'h72); send_byte(8'h69);
        send_byte(8'h73); send_byte(8'h68); send_byte(8'h21);
        send_complete(1'b0, 8'h00);

        // Empty message
        push_exp(1'b1, {8'h80, 504'h0});
        send_complete(1'b0, 8'h00);

        // 55 zero bytes: length still fits
        push_exp(1'b1, {440'h0, 8'h80, 64'h1B8});
        for (int i = 0; i < 55; i++) send_byte(8'h00);
        send_complete(1'b0, 8'h00);

        // 56 zero bytes: length spills into a second block
        push_exp(1'b0, {448'h0, 8'h80, 56'h0});
        push_exp(1'b1, {448'h0, 64'h1C0});
        for (int i = 0; i < 56; i++) send_byte(8'h00);
        send_complete(1'b0, 8'h00);

        // 63 bytes: 0x80 lands in the final byte slot
        push_exp(1'b0, {{63{8'h5A}}, 8'h80});
        push_exp(1'b1, {448'h0, 64'h1F8});
        for (int i = 0; i < 63; i++) send_byte(8'h5A);
        send_complete(1'b0, 8'h00);

        // 64 x 0xFF with a 5-cycle stall; bytes offered during the stall must be ignored
        wait_drain("drain_before_hold");
        block_ready = 1'b0;
        push_exp(1'b0, {512{1'b1}});
        push_exp(1'b1, {8'h80, 440'h0, 64'h200});
        for (int i = 0; i < 64; i++) send_byte(8'hFF);
        load_enable = 1'b1;
        input_data  = 8'hAA;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("hold_block_data", block_data, {512{1'b1}});
            check("hold_in_ready", {511'h0, in_ready}, 512'h0);
            check("hold_block_valid", {511'h0, block_valid}, 512'h1);
            @(posedge clock); #1;
        end
        load_enable = 1'b0;
        block_ready = 1'b1;
        send_complete(1'b0, 8'h00);

        // Reset after 30 bytes, then "abc"
        wait_drain("drain_before_reset_load");
        for (int i = 0; i < 30; i++) send_byte(8'h33);
        pulse_reset();
        push_exp(1'b1, ABC_BLK);
        send_abc();

        // Reset while a full block is waiting, then "abc"
        wait_drain("drain_before_reset_emit");
        block_ready = 1'b0;
        for (int i = 0; i < 64; i++) send_byte(8'h11);
        repeat (2) @(posedge clock);
        #1;
        pulse_reset();
        block_ready = 1'b1;
        push_exp(1'b1, ABC_BLK);
        send_abc();

        wait_drain("final_drain");
        repeat (5) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
